// File: rtl/ras_ctrl_pkg.sv
// Shared types and decode helpers for the fetch-side RAS controller.
// Optional occupancy tracking is enabled with RAS_CTRL_OCC_EN.
package ras_ctrl_pkg;

  localparam int MAX_IDS_DEF = 8;
  localparam int RAS_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    FULL = 2'd1,
    RECOVER = 2'd2
  } ras_ctrl_state_t;

  localparam logic [6:0] JAL_T = 7'b1101111;
  localparam logic [6:0] JALR_T = 7'b1100111;
  localparam logic [6:0] BRANCH_T = 7'b1100011;

  typedef struct packed {
    logic call;
    logic ret;
    logic swap;
    logic ctl;
  } ras_class_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/ras_interface.sv
// Handshake bundle between the fetch-side controller and the return
// address stack; fetch drives the strobes, the stack returns its top.
interface ras_interface;
  logic        push;
  logic        pop;
  logic [31:0] new_addr;
  logic        branch_fetched;
  logic        branch_retired;
  logic [31:0] addr;

  modport fetch (
    output push, pop, new_addr, branch_fetched, branch_retired,
    input  addr
  );

  modport ras (
    input  push, pop, new_addr, branch_fetched, branch_retired,
    output addr
  );
endinterface

// File: rtl/ras_call_decode.sv
// Combinational classifier of a fetched word into call, return,
// coroutine swap or plain control transfer.
module ras_call_decode
  import ras_ctrl_pkg::*;
(
  input  logic [31:0] instruction,
  output ras_class_t  cls
);

  logic [6:0] op;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic       jal;
  logic       jalr;
  logic       br;
  logic       rd_lk;
  logic       rs_lk;
  logic       unused_bits;

  assign op = instruction[6:0];
  assign rd = instruction[11:7];
  assign rs1 = instruction[19:15];
  assign unused_bits = ^{instruction[31:20], instruction[14:12]};

  assign jal = (op == JAL_T);
  assign jalr = (op == JALR_T);
  assign br = (op == BRANCH_T);
  assign rd_lk = is_link(rd);
  assign rs_lk = is_link(rs1);

  always_comb begin
    cls = '0;
    cls.ctl = jal | jalr | br;
    cls.call = (jal & rd_lk) |
      (jalr & rd_lk & (~rs_lk | (rd == rs1)));
    cls.ret = jalr & ~rd_lk & rs_lk;
    cls.swap = jalr & rd_lk & rs_lk & (rd != rs1);
  end

endmodule

// File: rtl/ras_ctrl.sv
// Fetch-side RAS driver: decodes calls/returns, tracks outstanding snapshots.
// Define RAS_CTRL_OCC_EN to gate predictions on a tracked stack occupancy.
module ras_ctrl
  import ras_ctrl_pkg::*;
#(
  parameter int MAX_IDS = MAX_IDS_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gc_fetch_flush,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instruction,
  input  logic [31:0] if_pc,
  input  logic        br_retire,
  output logic        pred_valid,
  output logic [31:0] pred_target,
  ras_interface.fetch ras
);

  localparam int CW = $clog2(MAX_IDS + 1);
  localparam logic [1:0] S_RUN = RUN;
  localparam logic [1:0] S_FULL = FULL;
  localparam logic [1:0] S_RECOVER = RECOVER;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [CW-1:0] next_count;
  ras_class_t    cls;
  logic          accept;
  logic          fetched;
  logic          retired;
  logic          occ_ok;

  ras_call_decode u_decode (
    .instruction(if_instruction),
    .cls(cls)
  );

  // A retire racing a flush is lost along with the snapshot fifo.
  assign retired = br_retire & (count != '0) & ~gc_fetch_flush;

  always_comb begin
    if_ready = 1'b0;
    case (state)
      S_RUN: if_ready = 1'b1;
      S_FULL: if_ready = ~cls.ctl | retired;
      default: if_ready = 1'b0;
    endcase
    if (gc_fetch_flush) if_ready = 1'b0;
  end

  assign accept = if_valid & if_ready;
  assign fetched = accept & cls.ctl;
  assign next_count = count + CW'(fetched) - CW'(retired);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      count <= '0;
    end else if (gc_fetch_flush) begin
      state <= S_RECOVER;
      count <= '0;
    end else begin
      count <= next_count;
      case (state)
        S_RUN:
          if (next_count == CW'(MAX_IDS)) state <= S_FULL;
        S_FULL:
          if (next_count < CW'(MAX_IDS)) state <= S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end

  assign ras.push = accept & (cls.call | cls.swap);
  assign ras.pop = accept & (cls.ret | cls.swap);
  assign ras.new_addr = accept ? (if_pc + 32'd4) : 32'd0;
  assign ras.branch_fetched = fetched;
  assign ras.branch_retired = retired;

`ifdef RAS_CTRL_OCC_EN
  localparam int OW = $clog2(RAS_DEPTH + 1);
  localparam int PW = (MAX_IDS > 1) ? $clog2(MAX_IDS) : 1;

  logic [OW-1:0] occ;
  logic [OW-1:0] occ_q [MAX_IDS];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(MAX_IDS - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (fetched && !gc_fetch_flush) occ_q[wr_ptr] <= occ;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (gc_fetch_flush) begin
      // Oldest live snapshot is the state before the mispredicted branch.
      if (count != '0) occ <= occ_q[rd_ptr];
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fetched) wr_ptr <= bump(wr_ptr);
      if (retired) rd_ptr <= bump(rd_ptr);
      if (ras.push && !ras.pop && occ != OW'(RAS_DEPTH))
        occ <= occ + 1'b1;
      else if (ras.pop && !ras.push && occ != '0)
        occ <= occ - 1'b1;
    end
  end

  assign occ_ok = (occ != '0);
`else
  localparam int unused_depth = RAS_DEPTH;
  assign occ_ok = 1'b1;
`endif

  assign pred_valid = accept & (cls.ret | cls.swap) & occ_ok;
  assign pred_target = ras.addr;

endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: directed table, corner sequences, random vs model.
module tb_ras_ctrl;

  localparam int MAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        valid;
  logic        retire;
  logic [31:0] ins;
  logic [31:0] pc;
  logic        ready;
  logic        pv;
  logic [31:0] pt;

  ras_interface ras_if ();

  ras_ctrl #(.MAX_IDS(MAX), .RAS_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .gc_fetch_flush(flush),
    .if_valid(valid),
    .if_ready(ready),
    .if_instruction(ins),
    .if_pc(pc),
    .br_retire(retire),
    .pred_valid(pv),
    .pred_target(pt),
    .ras(ras_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          m_count;
  bit          m_rec;
  logic [31:0] stk [$];

  bit          e_ready, e_push, e_pop, e_fet, e_ret, e_pv;
  logic [31:0] e_na;

  typedef struct {
    bit          fl;
    bit          v;
    logic [31:0] i;
    logic [31:0] p;
    bit          r;
    bit          rdy;
    bit          psh;
    bit          pp;
    bit          fet;
    bit          ret;
    bit          pvx;
    logic [31:0] na;
  } vec_t;

  vec_t tbl [$];

  function automatic logic [31:0] jal(input int rd);
    return {20'd0, 5'(rd), 7'h6f};
  endfunction

  function automatic logic [31:0] jalr(input int rd, input int rs1);
    return {12'd0, 5'(rs1), 3'd0, 5'(rd), 7'h67};
  endfunction

  localparam logic [31:0] BEQ = 32'h0000_0063;
  localparam logic [31:0] ADD = 32'h0000_0033;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  function automatic bit lk(input logic [4:0] r);
    return r == 5'd1 || r == 5'd5;
  endfunction

  task automatic model_eval();
    logic [6:0] op;
    logic [4:0] rd, rs;
    bit j, jr, ctl, call, ret, swp, acc;
    op = ins[6:0];
    rd = ins[11:7];
    rs = ins[19:15];
    j = op == 7'h6f;
    jr = op == 7'h67;
    ctl = j || jr || op == 7'h63;
    call = (j && lk(rd)) || (jr && lk(rd) && (!lk(rs) || rd == rs));
    ret = jr && !lk(rd) && lk(rs);
    swp = jr && lk(rd) && lk(rs) && rd != rs;
    e_ret = retire && m_count > 0 && !flush;
    e_ready = !flush && !m_rec && (m_count < MAX || !ctl || e_ret);
    acc = valid && e_ready;
    e_fet = acc && ctl;
    e_push = acc && (call || swp);
    e_pop = acc && (ret || swp);
    e_pv = e_pop;
    e_na = acc ? pc + 32'd4 : 32'd0;
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".ready"}, 32'(ready), 32'(e_ready));
    chk({tag, ".push"}, 32'(ras_if.push), 32'(e_push));
    chk({tag, ".pop"}, 32'(ras_if.pop), 32'(e_pop));
    chk({tag, ".fetched"}, 32'(ras_if.branch_fetched), 32'(e_fet));
    chk({tag, ".retired"}, 32'(ras_if.branch_retired), 32'(e_ret));
    chk({tag, ".pred_valid"}, 32'(pv), 32'(e_pv));
    chk({tag, ".new_addr"}, ras_if.new_addr, e_na);
    chk({tag, ".pred_target"}, pt, ras_if.addr);
  endtask

  task automatic apply(input bit fl, input bit v, input logic [31:0] i,
                       input logic [31:0] p, input bit r);
    @(negedge clk);
    flush = fl;
    valid = v;
    ins = i;
    pc = p;
    retire = r;
    ras_if.addr = stk.size() != 0 ? stk[$] : 32'd0;
    #1;
    model_eval();
  endtask

  task automatic commit();
    @(posedge clk);
    if (flush) begin
      m_count = 0;
      m_rec = 1;
    end else begin
      m_rec = 0;
      m_count = m_count + int'(e_fet) - int'(e_ret);
    end
    if (e_pop && stk.size() != 0) void'(stk.pop_back());
    if (e_push) stk.push_back(pc + 32'd4);
  endtask

  task automatic step(input string tag, input bit fl, input bit v,
                      input logic [31:0] i, input logic [31:0] p,
                      input bit r);
    apply(fl, v, i, p, r);
    model_check(tag);
    commit();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    flush = 0;
    valid = 0;
    retire = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_count = 0;
    m_rec = 0;
    stk.delete();
  endtask

  function automatic vec_t mk(bit fl, bit v, logic [31:0] i,
                              logic [31:0] p, bit r, bit rdy, bit psh,
                              bit pp, bit fet, bit ret, bit pvx,
                              logic [31:0] na);
    vec_t x;
    x.fl = fl; x.v = v; x.i = i; x.p = p; x.r = r;
    x.rdy = rdy; x.psh = psh; x.pp = pp; x.fet = fet;
    x.ret = ret; x.pvx = pvx; x.na = na;
    return x;
  endfunction

  initial begin
    rst = 1'b1;
    flush = 0;
    valid = 0;
    retire = 0;
    ins = 0;
    pc = 0;
    ras_if.addr = 0;

    tbl.push_back(mk(0,0,ADD,32'h0,0, 1,0,0,0,0,0, 32'h0));
    tbl.push_back(mk(0,1,jal(1),32'h100,0, 1,1,0,1,0,0, 32'h104));
    tbl.push_back(mk(0,1,jalr(0,1),32'h180,0, 1,0,1,1,0,1, 32'h184));
    tbl.push_back(mk(0,1,jal(5),32'h1f0,0, 1,1,0,1,0,0, 32'h1f4));
    tbl.push_back(mk(0,1,jalr(5,1),32'h200,0, 1,1,1,1,0,1, 32'h204));
    tbl.push_back(mk(0,1,jalr(1,1),32'h300,0, 1,1,0,1,0,0, 32'h304));
    tbl.push_back(mk(0,1,jalr(6,6),32'h400,0, 1,0,0,1,0,0, 32'h404));
    tbl.push_back(mk(0,1,jal(0),32'hffff_fffc,0, 1,0,0,1,0,0, 32'h0));
    tbl.push_back(mk(0,1,BEQ,32'h500,0, 1,0,0,1,0,0, 32'h504));
    tbl.push_back(mk(0,1,BEQ,32'h504,0, 0,0,0,0,0,0, 32'h0));
    tbl.push_back(mk(0,1,ADD,32'h504,0, 1,0,0,0,0,0, 32'h508));
    tbl.push_back(mk(0,1,BEQ,32'h508,1, 1,0,0,1,1,0, 32'h50c));
    tbl.push_back(mk(0,1,BEQ,32'h50c,0, 0,0,0,0,0,0, 32'h0));
    tbl.push_back(mk(0,0,ADD,32'h0,1, 1,0,0,0,1,0, 32'h0));
    tbl.push_back(mk(0,1,BEQ,32'h510,0, 1,0,0,1,0,0, 32'h514));

    do_reset();

    foreach (tbl[k]) begin
      string n;
      n = $sformatf("vec%0d", k);
      apply(tbl[k].fl, tbl[k].v, tbl[k].i, tbl[k].p, tbl[k].r);
      chk({n, ".ready"}, 32'(ready), 32'(tbl[k].rdy));
      chk({n, ".push"}, 32'(ras_if.push), 32'(tbl[k].psh));
      chk({n, ".pop"}, 32'(ras_if.pop), 32'(tbl[k].pp));
      chk({n, ".fetched"}, 32'(ras_if.branch_fetched), 32'(tbl[k].fet));
      chk({n, ".retired"}, 32'(ras_if.branch_retired), 32'(tbl[k].ret));
      chk({n, ".pred_valid"}, 32'(pv), 32'(tbl[k].pvx));
      chk({n, ".new_addr"}, ras_if.new_addr, tbl[k].na);
      chk({n, ".pred_target"}, pt, ras_if.addr);
      commit();
    end

    // Flush with five outstanding and a call presented.
    do_reset();
    for (int k = 0; k < 5; k++) step("pre", 0, 1, BEQ, 32'h600, 0);
    apply(1, 1, jal(1), 32'h700, 0);
    chk("flush.ready", 32'(ready), 32'd0);
    chk("flush.push", 32'(ras_if.push), 32'd0);
    chk("flush.fetched", 32'(ras_if.branch_fetched), 32'd0);
    commit();
    apply(0, 1, jal(1), 32'h700, 0);
    chk("recover.ready", 32'(ready), 32'd0);
    chk("recover.push", 32'(ras_if.push), 32'd0);
    commit();
    apply(0, 1, jal(1), 32'h700, 0);
    chk("post.ready", 32'(ready), 32'd1);
    chk("post.push", 32'(ras_if.push), 32'd1);
    commit();
    for (int k = 0; k < 7; k++) step("refill", 0, 1, BEQ, 32'h800, 0);
    apply(0, 1, BEQ, 32'h900, 0);
    chk("refill.full", 32'(ready), 32'd0);
    commit();
    for (int k = 0; k < 8; k++) step("drain", 0, 0, ADD, 32'h0, 1);
    apply(0, 0, ADD, 32'h0, 1);
    chk("retire0.retired", 32'(ras_if.branch_retired), 32'd0);
    commit();
    apply(0, 0, ADD, 32'h0, 1);
    chk("retire0.again", 32'(ras_if.branch_retired), 32'd0);
    commit();

    // Reset while FULL.
    for (int k = 0; k < 8; k++) step("fill", 0, 1, BEQ, 32'ha00, 0);
    do_reset();
    apply(0, 1, BEQ, 32'hb00, 0);
    chk("rstfull.ready", 32'(ready), 32'd1);
    chk("rstfull.fetched", 32'(ras_if.branch_fetched), 32'd1);
    commit();
    for (int k = 0; k < 7; k++) step("rstfill", 0, 1, BEQ, 32'hb04, 0);
    apply(0, 1, BEQ, 32'hc00, 0);
    chk("rstfill.full", 32'(ready), 32'd0);
    commit();

    // Randomized traffic against the reference model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      int rsel [4] = '{0, 1, 5, 6};
      logic [31:0] ri;
      case ($urandom_range(0, 3))
        0: ri = jal(rsel[$urandom_range(0, 3)]);
        1: ri = jalr(rsel[$urandom_range(0, 3)], rsel[$urandom_range(0, 3)]);
        2: ri = BEQ;
        default: ri = ADD;
      endcase
      step("rand", $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
           ri, $urandom() & 32'hffff_fffc, $urandom_range(0, 9) < 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
- Fetch-side driver of the return address stack: initiator/writer end of ras_interface.
- Decodes each accepted fetch-stage instruction, classifies it as call / return / coroutine swap / other control transfer, and drives push, pop, new_addr and branch_fetched.
- Tracks outstanding speculative snapshots, so it drives branch_retired and back-pressures fetch when the snapshot FIFO would overflow.
- Supplies the return-target prediction to the PC-select logic.

Parameters:
- MAX_IDS, 8, outstanding speculative snapshots the RAS can hold; must equal the RAS snapshot FIFO depth.
- RAS_DEPTH, 4, RAS entry count; used only by the optional occupancy tracker.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- gc_fetch_flush  input  1  misprediction/GC flush; RAS restores its snapshot this cycle
- if_valid  input  1  instruction/PC valid at fetch decode
- if_ready  output  1  fetch may accept the instruction this cycle
- if_instruction  input  32  fetched instruction word
- if_pc  input  32  PC of if_instruction
- br_retire  input  1  oldest outstanding control transfer resolved/retired
- pred_valid  output  1  return predicted this cycle
- pred_target  output  32  predicted return target (ras.addr)
- ras  ras_interface.fetch  -  drives push, pop, new_addr, branch_fetched, branch_retired; reads addr

Behaviour:
- accept = if_valid & if_ready. All ras outputs are combinational from accept, decode and state; they are zero whenever accept=0.
- Decode rules; link(r) = r in {x1, x5}:
  - JAL with link(rd): call.
  - JALR, link(rd), !link(rs1): call.
  - JALR, !link(rd), link(rs1): return.
  - JALR, link(rd), link(rs1), rd!=rs1: swap (pop+push).
  - JALR, link(rd), link(rs1), rd==rs1: call.
  - Other JAL/JALR/BRANCH opcodes: ctl only.
- push = accept & (call|swap). pop = accept & (return|swap). new_addr = if_pc + 4, 32-bit, wraps modulo 2^32.
- branch_fetched = accept & (JAL|JALR|BRANCH).
- pred_valid = accept & (return|swap); pred_target = ras.addr in the same cycle.
- branch_retired = br_retire & (count != 0). A retire when count=0 is ignored.
- count: width clog2(MAX_IDS+1); reset 0; next = count + fetched - retired.
- States: RUN, FULL, RECOVER. Reset state RUN.
  - RUN: if_ready=1. If next count == MAX_IDS, go to FULL.
  - FULL: if_ready=1 only when if_instruction is not a control transfer or branch_retired=1. Leave to RUN when next count < MAX_IDS.
  - Any state, gc_fetch_flush=1: count <= 0, state <= RECOVER. In the flush cycle if_ready=0, so no push/pop/fetched is issued; the RAS applies only its snapshot restore.
  - RECOVER: lasts exactly one cycle with if_ready=0 (redirect bubble), then RUN.
- A retire in the same cycle as a flush is dropped (snapshot FIFO also resets).
- Simultaneous fetched and retired in FULL: count unchanged; stays FULL.
- Reset values: if_ready=1, all ras outputs 0, pred_valid 0, count 0.
- Reset mid-operation overrides flush.
- Zero cycle latency from accept to RAS strobes. Back-to-back returns are correct because the RAS read index updates at the clock edge.

Optional Feature:
- Macro: RAS_CTRL_OCC_EN.
- Defined:
  - Adds a saturating occupancy counter, 0..RAS_DEPTH.
  - Occupancy is snapshotted per branch_fetched into a MAX_IDS-deep fifo and restored on flush.
  - pred_valid is additionally gated by occupancy != 0, so a return on an empty stack is not predicted.
- Undefined:
  - No occupancy tracking.
  - pred_valid follows the decode rule only.

Decomposition:
- taiga_types/taiga_config provide MAX_IDS and RAS_DEPTH.
- Add to the package:
  - ras_ctrl_state_t enum {RUN, FULL, RECOVER}
  - opcode constants JAL_T, JALR_T, BRANCH_T
  - link-register helper function
- One natural sub-module, ras_call_decode: purely combinational classifier (call/return/swap/ctl).
- The occupancy fifo reuses taiga_fifo.

Test Plan:
- JAL x1 at pc=0x100 -> push=1, new_addr=0x104, branch_fetched=1, count 0->1.
- Call at 0x100, later JALR x0,0(x1) -> pop=1, pred_valid=1, pred_target=0x104.
- JALR x5,0(x1) at 0x200 -> push=1 and pop=1 same cycle, new_addr=0x204, pred_target = prior top.
- With MAX_IDS=8: 8 branches with no retire -> FULL, if_ready=0 for a 9th BEQ but 1 for an ADD; a br_retire pulse -> that BEQ accepted, count stays 8.
- gc_fetch_flush with count=5 and a call at if_valid -> no push, count=0, if_ready=0 for that cycle and one RECOVER cycle, then 1.
- br_retire with count=0 -> branch_retired=0, count stays 0. Reset during FULL -> RUN, count=0, if_ready=1 next cycle.
